// File: rtl/rw_reg_pkg.sv
// Purpose: shared constants and helpers for the byte-lane read/write register.
//   LANE_W             : bits per write-strobe lane
//   DEFAULT_DATA_WIDTH : default stored-value width
//   lane_count()       : number of strobe lanes for a given data width
//   lane_width()       : width of lane idx (the last lane may be partial)
package rw_reg_pkg;

  localparam int unsigned LANE_W             = 8;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  function automatic int unsigned lane_count(input int unsigned dw);
    return (dw + LANE_W - 1) / LANE_W;
  endfunction

  function automatic int unsigned lane_width(input int unsigned dw, input int unsigned idx);
    return ((dw - idx * LANE_W) >= LANE_W) ? LANE_W : (dw - idx * LANE_W);
  endfunction

endpackage

// File: rtl/rw_reg_unit_if.sv
// Purpose: write bus plus register readback for rw_reg_unit.
//   wen, wstrb, value_in : write request (master -> slave)
//   value_out, wr_ack    : stored value and write acknowledge (slave -> master)
//   changed              : change-detect pulse, only with RW_REG_CHANGE_EN defined
interface rw_reg_unit_if
  import rw_reg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  localparam int unsigned NLANES = lane_count(DATA_WIDTH);

  logic                  wen;
  logic [NLANES-1:0]     wstrb;
  logic [DATA_WIDTH-1:0] value_in;
  logic [DATA_WIDTH-1:0] value_out;
  logic                  wr_ack;
`ifdef RW_REG_CHANGE_EN
  logic                  changed;
`endif

  modport master (
    output wen, wstrb, value_in,
`ifdef RW_REG_CHANGE_EN
    input  changed,
`endif
    input  value_out, wr_ack
  );

  modport slave (
    input  wen, wstrb, value_in,
`ifdef RW_REG_CHANGE_EN
    output changed,
`endif
    output value_out, wr_ack
  );

endinterface

// File: rtl/rw_reg_lane.sv
// Purpose: one strobe-qualified byte-lane register (possibly a partial lane).
//   clk, rstn : clock and asynchronous active-high reset
//   load      : lane write request (wen & wstrb[i])
//   d         : lane slice of the write data
//   q         : registered lane value
// With HAS_RESET=0 the register has no reset and powers up undefined.
module rw_reg_lane #(
  parameter int unsigned W         = 8,
  parameter bit          HAS_RESET = 1'b1,
  parameter logic [W-1:0] RST_VAL  = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // A write is never accepted while reset is held, even for a non-reset lane.
  logic load_ok_c;
  assign load_ok_c = load & ~rstn;

  generate
    if (HAS_RESET) begin : g_rst
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn)           q <= RST_VAL;
        else if (load_ok_c) q <= d;
      end
    end else begin : g_nrst
      always_ff @(posedge clk) begin
        if (load_ok_c) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/rw_reg_unit.sv
// Purpose: byte-strobed read/write register with 1-cycle write latency.
//   clk, rstn : clock and asynchronous active-high reset
//   bus       : rw_reg_unit_if slave (wen/wstrb/value_in in, value_out/wr_ack out)
// Optional macro RW_REG_CHANGE_EN adds the registered 'changed' pulse.
module rw_reg_unit
  import rw_reg_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned           HAS_RESET   = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic         clk,
  input logic         rstn,
  rw_reg_unit_if.slave bus
);

  localparam int unsigned NLANES = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] value_q;
  logic                  wr_ack_q;

  // One register per strobe lane; the last lane is narrowed to the remaining bits.
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    localparam int unsigned LO = i * LANE_W;
    localparam int unsigned LW = lane_width(DATA_WIDTH, i);

    rw_reg_lane #(
      .W         (LW),
      .HAS_RESET (HAS_RESET != 0),
      .RST_VAL   (RESET_VALUE[LO +: LW])
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .load (bus.wen & bus.wstrb[i]),
      .d    (bus.value_in[LO +: LW]),
      .q    (value_q[LO +: LW])
    );
  end

  // Every accepted write is acknowledged, including all-zero strobes.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) wr_ack_q <= 1'b0;
    else      wr_ack_q <= bus.wen;
  end

  assign bus.value_out = value_q;
  assign bus.wr_ack    = wr_ack_q;

`ifdef RW_REG_CHANGE_EN
  logic [DATA_WIDTH-1:0] mask_c;
  logic [DATA_WIDTH-1:0] merged_c;
  logic                  changed_q;

  // Value the register will hold after this edge if the write is accepted.
  always_comb begin
    mask_c = '0;
    for (int b = 0; b < int'(DATA_WIDTH); b++) begin
      mask_c[b] = bus.wstrb[b / int'(LANE_W)];
    end
    merged_c = (value_q & ~mask_c) | (bus.value_in & mask_c);
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) changed_q <= 1'b0;
    else      changed_q <= bus.wen & (|(merged_c ^ value_q));
  end

  assign bus.changed = changed_q;
`endif

endmodule

// File: tb/tb_rw_reg_unit.sv
// Purpose: directed self-checking bench for rw_reg_unit (DATA_WIDTH=16).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_rw_reg_unit;

  logic clk;
  logic rstn;

  int n_checks;
  int n_errors;

  rw_reg_unit_if #(.DATA_WIDTH(16)) bus ();

  rw_reg_unit #(
    .DATA_WIDTH  (16),
    .HAS_RESET   (1),
    .RESET_VALUE (16'h0000)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] vec [10];

  initial begin
    n_checks = 0;
    n_errors = 0;
    vec[0] = 16'hA5C3; vec[1] = 16'h1234; vec[2] = 16'hFFFF; vec[3] = 16'h0000;
    vec[4] = 16'h8001; vec[5] = 16'h7E7E; vec[6] = 16'h00FF; vec[7] = 16'hFF00;
    vec[8] = 16'h3C3C; vec[9] = 16'hA5C3;

    rstn         = 1'b1;
    bus.wen      = 1'b0;
    bus.wstrb    = 2'b00;
    bus.value_in = 16'h0000;
    tick();
    tick();

    // Reset state
    check("rst_value", 32'(bus.value_out), 32'h0000);
    check("rst_ack", 32'(bus.wr_ack), 32'h0);
`ifdef RW_REG_CHANGE_EN
    check("rst_changed", 32'(bus.changed), 32'h0);
`endif

    // Ten back-to-back full writes, first accepted right after reset release
    rstn = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.wen      = 1'b1;
      bus.wstrb    = 2'b11;
      bus.value_in = vec[k];
      tick();
      check($sformatf("full_value_%0d", k), 32'(bus.value_out), 32'(vec[k]));
      check($sformatf("full_ack_%0d", k), 32'(bus.wr_ack), 32'h1);
    end

    // Byte strobes: stored A5C3
    bus.wstrb = 2'b01; bus.value_in = 16'h1234;
    tick();
    check("strb_lo_value", 32'(bus.value_out), 32'hA534);
    bus.wstrb = 2'b10; bus.value_in = 16'hFF00;
    tick();
    check("strb_hi_value", 32'(bus.value_out), 32'hFF34);
    bus.wstrb = 2'b00; bus.value_in = 16'h0000;
    tick();
    check("strb_none_value", 32'(bus.value_out), 32'hFF34);
    check("strb_none_ack", 32'(bus.wr_ack), 32'h1);

    // Hold: wen low with changing data and strobes
    bus.wen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.wstrb    = 2'b11;
      bus.value_in = vec[k] ^ 16'h5555;
      tick();
      check($sformatf("hold_value_%0d", k), 32'(bus.value_out), 32'hFF34);
      check($sformatf("hold_ack_%0d", k), 32'(bus.wr_ack), 32'h0);
    end

`ifdef RW_REG_CHANGE_EN
    // Change detect
    bus.wen = 1'b1; bus.wstrb = 2'b11; bus.value_in = 16'h1234;
    tick();
    check("chg_first", 32'(bus.changed), 32'h1);
    tick();
    check("chg_same_value", 32'(bus.value_out), 32'h1234);
    check("chg_same", 32'(bus.changed), 32'h0);
    check("chg_same_ack", 32'(bus.wr_ack), 32'h1);
    bus.value_in = 16'h1235;
    tick();
    check("chg_diff", 32'(bus.changed), 32'h1);
    bus.wen = 1'b0;
    tick();
    check("chg_pulse_end", 32'(bus.changed), 32'h0);
    bus.wen = 1'b1; bus.wstrb = 2'b01; bus.value_in = 16'h0035;
    tick();
    check("chg_masked_same", 32'(bus.changed), 32'h0);
`endif

    // Full write so wr_ack is high going into reset
    bus.wen = 1'b1; bus.wstrb = 2'b11; bus.value_in = 16'h5A5A;
    tick();
    check("pre_rst_value", 32'(bus.value_out), 32'h5A5A);
    check("pre_rst_ack", 32'(bus.wr_ack), 32'h1);

    // Reset asserted mid-cycle together with a write: clears asynchronously, write lost
    bus.value_in = 16'hBEEF;
    rstn = 1'b1;
    #1;
    check("async_rst_value", 32'(bus.value_out), 32'h0000);
    check("async_rst_ack", 32'(bus.wr_ack), 32'h0);
    tick();
    check("rst_wr_value", 32'(bus.value_out), 32'h0000);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'h0);
`ifdef RW_REG_CHANGE_EN
    check("rst_wr_changed", 32'(bus.changed), 32'h0);
`endif

    // First edge after release accepts the write
    rstn = 1'b0;
    bus.value_in = 16'h0F0F;
    tick();
    check("post_rst_value", 32'(bus.value_out), 32'h0F0F);
    check("post_rst_ack", 32'(bus.wr_ack), 32'h1);
    bus.wen = 1'b0;
    tick();
    check("post_rst_ack_end", 32'(bus.wr_ack), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
